vc_arbiter: RTL
===============

# vc_arbiter

Transmit-path arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). Each cycle it selects at most one VC head word, pops it, and pushes it one cycle later into the destination FIFO named by the word's destination bit, honouring destination back-pressure. It also latches and distributes FIFO thresholds during the init phase, and reports link idle to the top-level state machine.

## Interface
- DATA_WIDTH, 6, word width
- DEST_BIT, 4, bit index of the destination select (0 → D0, 1 → D1)
- UMBRAL_WIDTH, 4, threshold width
- W0, 3, VC0 grants per round (WRR only)
- W1, 1, VC1 grants per round (WRR only)

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- init  in  1  init phase request, active-high
- umbral_vc_in  in  UMBRAL_WIDTH  VC FIFO threshold to distribute
- umbral_d_in  in  UMBRAL_WIDTH  D FIFO threshold to distribute
- vc0_head, vc1_head  in  DATA_WIDTH  current head word of each VC FIFO (peek, non-popping)
- vc0_empty, vc1_empty  in  1  VC FIFO empty
- d0_almost_full, d1_almost_full  in  1  destination back-pressure
- vc0_pop, vc1_pop  out  1  combinational pop strobe, one-hot or zero
- d0_push, d1_push  out  1  registered push strobe
- data_out  out  DATA_WIDTH  registered word for D0/D1
- umbral_vc_out, umbral_d_out  out  UMBRAL_WIDTH  latched thresholds
- idle  out  1  registered; 1 when no traffic is pending

## Operation
- States: RESET, INIT, IDLE, ACTIVE.
- RESET: entered while reset=0. All registers and outputs are 0, except idle=0. Exits to INIT next cycle if init=1, otherwise to IDLE.
- INIT: umbral_*_out load umbral_*_in every cycle. No grants are issued. When init=0, goes to IDLE. init=1 in any state forces INIT on the next cycle; an in-flight push still completes.
- IDLE: idle=1. Goes to ACTIVE when either VC is non-empty.
- ACTIVE: idle=0. Goes to IDLE when both VCs are empty and no push is in flight.
- VCx is eligible when vcx_empty=0 and the almost_full of its head's destination is 0.
- Arbitration is strict priority, VC0 over VC1. There is no head-of-line blocking across VCs: if VC0 is ineligible, VC1 may be granted.
- A grant asserts vcx_pop in the same cycle. In the next cycle, data_out=head and d[head[DEST_BIT]]_push=1.
- When there is no grant, pushes are 0 and data_out holds its last value.
- Thresholds are only changed in INIT.

## Timing
- Pop-to-push latency is exactly 1 cycle. Throughput is 1 word/cycle sustained.
- vcx_pop is a combinational function of state, empties, heads and almost_fulls. It has no path from the push registers.
- almost_full must rise with at least 1 word of slack. The arbiter may push one word in the cycle after almost_full rises.
- If reset goes low mid-transfer, the pending push is dropped and all outputs read 0 on the next edge.
- Both VCs eligible for the same destination: VC0 wins, and VC1 waits with its head unchanged.

## Configuration
- ARB_WRR_EN defined: weighted round robin. A credit counter grants up to W0 consecutive VC0 words, then up to W1 VC1 words.
  - Credit passes early when the owning VC is ineligible.
  - Credits reload when both credit counts reach 0 or in RESET/INIT.
- ARB_WRR_EN undefined: strict priority as above. W0 and W1 are ignored and the counter is not synthesized.

## Structure
- Shared package vc_arb_pkg holds the state enum (RESET, INIT, IDLE, ACTIVE), the DEST_BIT default, and the threshold width constant.
- One sub-module, vc_arb_sel, holds the eligibility/grant logic, including the WRR credit counter under ARB_WRR_EN.
- The FSM, output registers and threshold latches live in vc_arbiter.

## Test plan
- Reset/init:
  - Stimulus: reset=0 for 2 cycles, then init=1 with umbral_vc_in=2 and umbral_d_in=3, then init=0.
  - Required: all outputs 0 during reset; umbral outs 2/3 after the first INIT edge; idle=1 after exit.
- Priority:
  - Stimulus: both VCs non-empty, heads 0x05 (D0) and 0x13 (D1), no back-pressure.
  - Required: vc0_pop first, then d0_push with data_out=0x05 one cycle later; vc1 served only after VC0 is empty (strict mode).
- Back-pressure bypass:
  - Stimulus: d0_almost_full=1, VC0 head to D0, VC1 head 0x1A (D1).
  - Required: vc1_pop; d1_push with 0x1A next cycle; vc0_pop stays 0 until d0_almost_full=0.
- Drain to idle:
  - Stimulus: 4 words in VC1, VC0 empty.
  - Required: 4 consecutive pushes; idle=1 on the cycle after the last push.
- Mid-transfer reset:
  - Stimulus: assert reset=0 in the cycle a pop occurs.
  - Required: no push on the next edge; all outputs 0.
- WRR (ARB_WRR_EN, W0=3, W1=1):
  - Stimulus: both VCs continuously eligible.
  - Required: grant pattern 0,0,0,1 repeats.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared types and constants for the VC transmit-path arbiter.
package vc_arb_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        StReset  = 2'd0,
        StInit   = 2'd1,
        StIdle   = 2'd2,
        StActive = 2'd3
    } arb_state_e;

    localparam int unsigned DataWidthDefault   = 6;
    localparam int unsigned DestBitDefault     = 4;
    localparam int unsigned UmbralWidthDefault = 4;

    // A head word is blocked when the destination it selects is almost full.
    function automatic logic dest_blocked(logic dest, logic d0_af, logic d1_af);
        return dest ? d1_af : d0_af;
    endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// Bus between the arbiter, the two VC FIFOs, the two destination FIFOs and
// the threshold source. slave = arbiter side, master = environment side.
interface vc_arbiter_if
    import vc_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DataWidthDefault,
    parameter int unsigned UMBRAL_WIDTH = UmbralWidthDefault
);
    logic                    init;
    logic [UMBRAL_WIDTH-1:0] umbral_vc_in;
    logic [UMBRAL_WIDTH-1:0] umbral_d_in;
    logic [DATA_WIDTH-1:0]   vc0_head;
    logic [DATA_WIDTH-1:0]   vc1_head;
    logic                    vc0_empty;
    logic                    vc1_empty;
    logic                    d0_almost_full;
    logic                    d1_almost_full;
    logic                    vc0_pop;
    logic                    vc1_pop;
    logic                    d0_push;
    logic                    d1_push;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [UMBRAL_WIDTH-1:0] umbral_vc_out;
    logic [UMBRAL_WIDTH-1:0] umbral_d_out;
    logic                    idle;

    modport slave (
        input  init, umbral_vc_in, umbral_d_in, vc0_head, vc1_head, vc0_empty, vc1_empty,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, data_out, umbral_vc_out, umbral_d_out, idle
    );

    modport master (
        output init, umbral_vc_in, umbral_d_in, vc0_head, vc1_head, vc0_empty, vc1_empty,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, umbral_vc_out, umbral_d_out, idle
    );

endinterface

// File: rtl/vc_arb_sel.sv
// Eligibility and grant selection between VC0 and VC1.
// Default build: strict priority, VC0 over VC1.
// ARB_WRR_EN defined: weighted round robin, W0 VC0 grants then W1 VC1 grants.
module vc_arb_sel
    import vc_arb_pkg::*;
#(
    parameter int unsigned W0 = 3,
    parameter int unsigned W1 = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic credit_clr,
    input  logic grant_en,
    input  logic vc0_empty,
    input  logic vc1_empty,
    input  logic vc0_dest,
    input  logic vc1_dest,
    input  logic d0_almost_full,
    input  logic d1_almost_full,
    output logic vc0_grant,
    output logic vc1_grant
);
    logic vc0_elig, vc1_elig;

    assign vc0_elig = !vc0_empty && !dest_blocked(vc0_dest, d0_almost_full, d1_almost_full);
    assign vc1_elig = !vc1_empty && !dest_blocked(vc1_dest, d0_almost_full, d1_almost_full);

`ifdef ARB_WRR_EN
    localparam int unsigned CredW = $clog2(((W0 > W1) ? W0 : W1) + 1);

    logic [CredW-1:0] cred0_q, cred0_d, cred1_q, cred1_d;

    // Grant the credit owner when eligible, otherwise hand the turn over early.
    always_comb begin
        cred0_d   = cred0_q;
        cred1_d   = cred1_q;
        vc0_grant = 1'b0;
        vc1_grant = 1'b0;
        if (grant_en) begin
            if (cred0_q != '0) begin
                if (vc0_elig) begin
                    vc0_grant = 1'b1;
                    cred0_d   = cred0_q - CredW'(1);
                end else begin
                    cred0_d = '0;
                    if (vc1_elig) begin
                        vc1_grant = 1'b1;
                        if (cred1_q != '0) cred1_d = cred1_q - CredW'(1);
                    end
                end
            end else begin
                if (vc1_elig) begin
                    vc1_grant = 1'b1;
                    if (cred1_q != '0) cred1_d = cred1_q - CredW'(1);
                end else begin
                    cred1_d = '0;
                    vc0_grant = vc0_elig;
                end
            end
        end
        if ((cred0_d == '0) && (cred1_d == '0)) begin
            cred0_d = CredW'(W0);
            cred1_d = CredW'(W1);
        end
    end

    // Credit counters reload outside the grant states.
    always_ff @(posedge clk) begin
        if (!reset || credit_clr) begin
            cred0_q <= CredW'(W0);
            cred1_q <= CredW'(W1);
        end else begin
            cred0_q <= cred0_d;
            cred1_q <= cred1_d;
        end
    end
`else
    logic        unused_ctrl;
    logic [31:0] unused_w;

    assign unused_ctrl = ^{clk, reset, credit_clr};
    assign unused_w    = W0 + W1;

    assign vc0_grant = grant_en && vc0_elig;
    assign vc1_grant = grant_en && vc1_elig && !vc0_elig;
`endif

endmodule

// File: rtl/vc_arbiter.sv
// Transmit-path arbiter: pops one VC head per cycle and pushes it into D0/D1
// one cycle later, latches thresholds during init, and reports link idle.
// Optional macro ARB_WRR_EN selects weighted round robin in vc_arb_sel.
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DataWidthDefault,
    parameter int unsigned DEST_BIT     = DestBitDefault,
    parameter int unsigned UMBRAL_WIDTH = UmbralWidthDefault,
    parameter int unsigned W0           = 3,
    parameter int unsigned W1           = 1
) (
    input logic         clk,
    input logic         reset,
    vc_arbiter_if.slave bus
);
    arb_state_e              state_q, state_d;
    logic                    grant_en;
    logic                    vc0_grant, vc1_grant, any_grant;
    logic [DATA_WIDTH-1:0]   grant_word;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    push0_q, push1_q;
    logic [UMBRAL_WIDTH-1:0] umbral_vc_q, umbral_d_q;

    // Grants only happen once the link is out of reset and init.
    assign grant_en   = (state_q == StIdle) || (state_q == StActive);
    assign any_grant  = vc0_grant || vc1_grant;
    assign grant_word = vc0_grant ? bus.vc0_head : bus.vc1_head;

    vc_arb_sel #(
        .W0 (W0),
        .W1 (W1)
    ) u_sel (
        .clk            (clk),
        .reset          (reset),
        .credit_clr     (!grant_en),
        .grant_en       (grant_en),
        .vc0_empty      (bus.vc0_empty),
        .vc1_empty      (bus.vc1_empty),
        .vc0_dest       (bus.vc0_head[DEST_BIT]),
        .vc1_dest       (bus.vc1_head[DEST_BIT]),
        .d0_almost_full (bus.d0_almost_full),
        .d1_almost_full (bus.d1_almost_full),
        .vc0_grant      (vc0_grant),
        .vc1_grant      (vc1_grant)
    );

    // Next-state logic; init overrides every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:  state_d = bus.init ? StInit : StIdle;
            StInit:   if (!bus.init) state_d = StIdle;
            StIdle:   if (!bus.vc0_empty || !bus.vc1_empty) state_d = StActive;
            StActive: if (bus.vc0_empty && bus.vc1_empty && !any_grant) state_d = StIdle;
            default:  state_d = StReset;
        endcase
        if (bus.init) state_d = StInit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= StReset;
        else        state_q <= state_d;
    end

    // Push strobes and data register; a grant becomes a push one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push0_q <= 1'b0;
            push1_q <= 1'b0;
            data_q  <= '0;
        end else begin
            push0_q <= any_grant && !grant_word[DEST_BIT];
            push1_q <= any_grant && grant_word[DEST_BIT];
            if (any_grant) data_q <= grant_word;
        end
    end

    // Threshold latches follow the inputs only while in INIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            umbral_vc_q <= '0;
            umbral_d_q  <= '0;
        end else if (state_q == StInit) begin
            umbral_vc_q <= bus.umbral_vc_in;
            umbral_d_q  <= bus.umbral_d_in;
        end
    end

    assign bus.vc0_pop       = vc0_grant;
    assign bus.vc1_pop       = vc1_grant;
    assign bus.d0_push       = push0_q;
    assign bus.d1_push       = push1_q;
    assign bus.data_out      = data_q;
    assign bus.umbral_vc_out = umbral_vc_q;
    assign bus.umbral_d_out  = umbral_d_q;
    assign bus.idle          = (state_q == StIdle);

endmodule
